mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- MEM-stage controller directly downstream of the EX/MEM control pipeline register.
- Consumes the registered MemRead/MemWrite/Branch controls. Runs a variable-latency req/ack handshake to data memory and returns load data toward MEM/WB.
- Raises mem_busy, which the pipeline uses to drop wen on upstream pipe registers.
- Resolves the branch-taken signal PCSrc.

Parameters:
ADDR_W, 32, byte-address width of alu_result / dmem_addr
DATA_W, 32, data word width

Ports:
clk  input  1  pipeline clock, all state updates on rising edge
reset  input  1  synchronous, active-high; one clock (clk), no other clock domains
MemRead  input  1  registered load control from EX/MEM pipe register
MemWrite  input  1  registered store control from EX/MEM pipe register
Branch  input  1  registered branch control from EX/MEM pipe register
Zero  input  1  ALU zero flag from EX/MEM
alu_result  input  ADDR_W  effective address
write_data  input  DATA_W  store data
dmem_req  output  1  memory request, registered
dmem_we  output  1  1 = write, 0 = read; valid while dmem_req
dmem_addr  output  ADDR_W  latched address
dmem_wdata  output  DATA_W  latched store data
dmem_ack  input  1  memory completion, one-cycle pulse
dmem_rdata  input  DATA_W  load data, valid with dmem_ack
read_data  output  DATA_W  captured load data toward MEM/WB
mem_busy  output  1  stall request, combinational; upstream wen = ~mem_busy
PCSrc  output  1  branch taken, combinational
misaligned  output  1  alignment fault pulse (0 unless feature enabled)

Behaviour:
- FSM states: IDLE, ACCESS, DONE.
- IDLE
  - If MemRead|MemWrite: latch alu_result, write_data and we=MemWrite. Go to ACCESS.
  - MemWrite has priority if both controls are high.
  - Otherwise stay in IDLE.
- ACCESS
  - dmem_req=1; dmem_we, dmem_addr and dmem_wdata stay stable for the whole state.
  - On dmem_ack: if read, read_data <= dmem_rdata. Go to DONE; dmem_req drops next cycle.
- DONE
  - Unconditionally go to IDLE.
  - Inputs still hold the completed op, so DONE never re-triggers. The pipe advances at the DONE edge.
- mem_busy = (IDLE & (MemRead|MemWrite)) | ACCESS; combinational.
  - Busy for 1+N cycles, where N = cycles spent in ACCESS (N>=1).
  - Minimum op: 3 cycles (detect, ACCESS with same-cycle ack, DONE).
- read_data is updated only on a read ack and held otherwise; writes never modify it.
- PCSrc = Branch & Zero & (state==IDLE). Zero-latency; branches never stall.
- dmem_ack outside ACCESS is ignored.
- Reset values: state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, read_data=0, misaligned=0. Combinational mem_busy/PCSrc follow from state=IDLE.
- Reset mid-ACCESS: next cycle dmem_req=0 and state=IDLE. The outstanding transaction is abandoned; memory must tolerate request withdrawal on reset.
- No flush input: a started memory op always completes.

Optional Feature:
MEM_ALIGN_CHECK_EN
- Defined:
  - An op in IDLE with alu_result[1:0]!=0 issues no request. It goes IDLE->DONE.
  - misaligned=1 for exactly the DONE cycle; mem_busy high only for the detect cycle; read_data unchanged.
- Undefined: misaligned tied 0; addresses pass through unchecked.

Decomposition:
- Shared package mem_ctrl_pkg holds:
  - state enum (IDLE, ACCESS, DONE);
  - default ADDR_W/DATA_W constants;
  - the alignment mask constant.
- Single FSM module; no natural sub-module.

Test Plan:
- Load, ack on first ACCESS cycle: MemRead=1, addr 0x100, dmem_rdata=0xDEADBEEF -> mem_busy high 2 cycles, dmem_req high 1 cycle with we=0, read_data=0xDEADBEEF from DONE onward.
- Store, ack after 4 ACCESS cycles: MemWrite=1, addr 0x40, data 0x12345678 -> dmem_req/we/addr/wdata stable 4 cycles, mem_busy high 5 cycles, read_data unchanged.
- Branch=1, Zero=1, no mem op -> PCSrc=1 same cycle, mem_busy=0. Branch=1, Zero=0 -> PCSrc=0.
- Back-to-back loads held by the stalled pipe register -> exactly two requests, separated by DONE and IDLE. No duplicate request while inputs are unchanged in DONE.
- reset asserted in 2nd ACCESS cycle -> next cycle dmem_req=0, state IDLE, read_data=0. A later stray dmem_ack is ignored.
- MEM_ALIGN_CHECK_EN defined, MemRead at addr 0x102 -> no dmem_req, misaligned pulses 1 cycle, mem_busy high 1 cycle.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the MEM-stage access controller: state encoding,
// default widths and the word-alignment mask.
package mem_ctrl_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   // Low address bits that must be zero for a word access
   localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: req/ack handshake to data memory, stall and branch resolve.
// Optional MEM_ALIGN_CHECK_EN rejects non-word-aligned accesses without a request.
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic              Branch,
   input  logic              Zero,
   input  logic [ADDR_W-1:0] alu_result,
   input  logic [DATA_W-1:0] write_data,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   input  logic              dmem_ack,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic [DATA_W-1:0] read_data,
   output logic              mem_busy,
   output logic              PCSrc,
   output logic              misaligned
);

   logic [1:0]        state_q, state_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              mis_q, mis_d;
   logic              op;
   logic              bad_align;

   assign op = MemRead | MemWrite;

`ifdef MEM_ALIGN_CHECK_EN
   assign bad_align = |(alu_result[1:0] & ALIGN_MASK);
`else
   assign bad_align = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      mis_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (op) begin
               addr_d  = alu_result;
               wdata_d = write_data;
               we_d    = MemWrite;
               // A rejected access still passes through DONE so the pipe sees one completion
               if (bad_align) begin
                  state_d = ST_DONE;
                  mis_d   = 1'b1;
               end else begin
                  state_d = ST_ACCESS;
                  req_d   = 1'b1;
               end
            end
         end
         ST_ACCESS: begin
            if (dmem_ack) begin
               if (!we_q) rdata_d = dmem_rdata;
               state_d = ST_DONE;
               req_d   = 1'b0;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         mis_q   <= mis_d;
      end
   end

   assign dmem_req   = req_q;
   assign dmem_we    = we_q;
   assign dmem_addr  = addr_q;
   assign dmem_wdata = wdata_q;
   assign read_data  = rdata_q;
   assign misaligned = mis_q;

   // DONE is not busy: the upstream pipe register loads at the DONE edge
   assign mem_busy = ((state_q == ST_IDLE) & op) | (state_q == ST_ACCESS);
   assign PCSrc    = Branch & Zero & (state_q == ST_IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: vector table with request scoreboard
// plus hand sequences for back-to-back, reset-abort and branch cases.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead, MemWrite, Branch, Zero;
   logic [31:0] alu_result, write_data;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata, read_data;
   logic        mem_busy, PCSrc, misaligned;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          lat;
      logic [31:0] exp_rd;
   } vec_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } exp_t;

   exp_t sb[$];

   mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .reset(reset),
      .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .Zero(Zero),
      .alu_result(alu_result), .write_data(write_data),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .read_data(read_data), .mem_busy(mem_busy), .PCSrc(PCSrc), .misaligned(misaligned)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_op(input vec_t v);
      int   busy_n, req_n;
      bit   done;
      exp_t cur;
      busy_n = 0;
      req_n  = 0;
      done   = 0;
      cur    = '{1'b0, 32'h0, 32'h0};
      MemRead    = v.rd;
      MemWrite   = v.wr;
      alu_result = v.addr;
      write_data = v.wdata;
      dmem_rdata = v.rdata;
      sb.push_back('{v.wr, v.addr, v.wdata});
      #1;
      for (int c = 0; c < 64; c++) begin
         if (!mem_busy) begin
            done = 1;
            break;
         end
         busy_n++;
         if (dmem_req) begin
            req_n++;
            if (req_n == 1) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb_underflow: got request with empty scoreboard");
               end else begin
                  cur = sb.pop_front();
               end
               chk("req_we", {31'd0, dmem_we}, {31'd0, cur.we});
               chk("req_addr", dmem_addr, cur.addr);
               chk("req_wdata", dmem_wdata, cur.wdata);
            end else begin
               chk("hold_addr", dmem_addr, cur.addr);
               chk("hold_we", {31'd0, dmem_we}, {31'd0, cur.we});
            end
         end
         dmem_ack = dmem_req && (req_n == v.lat);
         tick();
         dmem_ack = 1'b0;
      end
      chk("op_completed", {31'd0, done}, 32'd1);
      chk("busy_cycles", 32'(busy_n), 32'(v.lat + 1));
      chk("req_cycles", 32'(req_n), 32'(v.lat));
      chk("done_req_low", {31'd0, dmem_req}, 32'd0);
      chk("read_data", read_data, v.exp_rd);
      chk("misaligned_low", {31'd0, misaligned}, 32'd0);
      tick();
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      #1;
      chk("idle_not_busy", {31'd0, mem_busy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[5];
      logic [5:0] reqv, busyv;

      vecs[0] = '{1'b1, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 1, 32'hDEADBEEF};
      vecs[1] = '{1'b0, 1'b1, 32'h40,  32'h12345678, 32'h0,        4, 32'hDEADBEEF};
      vecs[2] = '{1'b1, 1'b1, 32'h80,  32'hAAAA5555, 32'h77777777, 2, 32'hDEADBEEF};
      vecs[3] = '{1'b1, 1'b0, 32'h200, 32'h0,        32'hCAFEF00D, 3, 32'hCAFEF00D};
      vecs[4] = '{1'b1, 1'b0, 32'h4,   32'h0,        32'hA5A5A5A5, 1, 32'hA5A5A5A5};

      reset = 1'b1;
      MemRead = 0; MemWrite = 0; Branch = 0; Zero = 0;
      alu_result = 0; write_data = 0; dmem_ack = 0; dmem_rdata = 0;
      tick();
      tick();
      chk("rst_req", {31'd0, dmem_req}, 32'd0);
      chk("rst_we", {31'd0, dmem_we}, 32'd0);
      chk("rst_addr", dmem_addr, 32'd0);
      chk("rst_wdata", dmem_wdata, 32'd0);
      chk("rst_read_data", read_data, 32'd0);
      chk("rst_busy", {31'd0, mem_busy}, 32'd0);
      chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 5; i++) run_op(vecs[i]);

      // Branch resolves in IDLE with zero latency
      Branch = 1; Zero = 1;
      #1;
      chk("pcsrc_taken", {31'd0, PCSrc}, 32'd1);
      chk("branch_no_busy", {31'd0, mem_busy}, 32'd0);
      Zero = 0;
      #1;
      chk("pcsrc_not_taken", {31'd0, PCSrc}, 32'd0);
      Branch = 0;
      tick();

      // Load held across DONE by the next instruction: two distinct requests
      MemRead = 1; alu_result = 32'h300; dmem_rdata = 32'h11112222;
      #1;
      for (int c = 0; c < 6; c++) begin
         reqv[c]  = dmem_req;
         busyv[c] = mem_busy;
         dmem_ack = dmem_req;
         tick();
         dmem_ack = 1'b0;
      end
      MemRead = 0;
      #1;
      chk("b2b_req_pattern", {26'd0, reqv}, 32'b010010);
      chk("b2b_busy_pattern", {26'd0, busyv}, 32'b011011);
      chk("b2b_read_data", read_data, 32'h11112222);
      tick();

      // Reset in the second ACCESS cycle abandons the transaction
      MemRead = 1; alu_result = 32'h500; dmem_rdata = 32'h99;
      tick();
      chk("abort_req1", {31'd0, dmem_req}, 32'd1);
      tick();
      Branch = 1; Zero = 1;
      #1;
      chk("abort_req2", {31'd0, dmem_req}, 32'd1);
      chk("pcsrc_blocked_access", {31'd0, PCSrc}, 32'd0);
      chk("access_busy", {31'd0, mem_busy}, 32'd1);
      reset = 1; MemRead = 0; Branch = 0; Zero = 0;
      tick();
      chk("abort_req_drop", {31'd0, dmem_req}, 32'd0);
      chk("abort_busy", {31'd0, mem_busy}, 32'd0);
      chk("abort_read_data", read_data, 32'd0);
      reset = 0;
      dmem_ack = 1; dmem_rdata = 32'hBADBAD00;
      tick();
      dmem_ack = 0;
      tick();
      chk("stray_ack_read_data", read_data, 32'd0);
      chk("stray_ack_req", {31'd0, dmem_req}, 32'd0);
      chk("stray_ack_busy", {31'd0, mem_busy}, 32'd0);

      run_op(vecs[0]);

`ifdef MEM_ALIGN_CHECK_EN
      MemRead = 1; alu_result = 32'h102; dmem_rdata = 32'h5A5A5A5A;
      #1;
      chk("mis_detect_busy", {31'd0, mem_busy}, 32'd1);
      tick();
      chk("mis_no_req", {31'd0, dmem_req}, 32'd0);
      chk("mis_pulse", {31'd0, misaligned}, 32'd1);
      chk("mis_done_busy", {31'd0, mem_busy}, 32'd0);
      MemRead = 0;
      tick();
      chk("mis_pulse_end", {31'd0, misaligned}, 32'd0);
      chk("mis_read_data", read_data, 32'hDEADBEEF);
`endif

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: got %0d pending expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
